fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  IF-stage PC owner and consumer of the ID-stage branch redirect (br_flag/br_addr).
//  Holds the PC and fetches one instruction at a time over a req/ready imem handshake.
//  Applies taken branches/jumps with an optional MIPS delay slot and drives the IF/ID
//  register (if_pc/if_instr/if_valid). Squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC    32'h0000_3000  first fetch address after reset
//  DELAY_SLOT  1              1: instr at br_pc+4 executes; 0: it is squashed
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst         in   1   synchronous reset, active-high
//  stall       in   1   hazard hold: ID does not consume IF/ID this cycle
//  id_valid    in   1   ID holds a real instruction (qualifies br_flag)
//  br_flag     in   1   redirect taken (from branch judge in ID)
//  br_addr     in   32  redirect target
//  br_pc       in   32  PC of the branch/jump in ID
//  imem_req    out  1   fetch request
//  imem_addr   out  32  fetch address, word aligned
//  imem_ready  in   1   imem_rdata valid; completes the request
//  imem_rdata  in   32  fetched instruction
//  if_pc       out  32  IF/ID PC
//  if_instr    out  32  IF/ID instruction
//  if_valid    out  1   IF/ID holds a valid instruction
//  flush_ifid  out  1   one-cycle pulse: IF/ID squashed by a redirect
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, if_pc=0, if_instr=0 (NOP), if_valid=0,
//   flush_ifid=0, skid empty, no pending redirect, no squash, state BOOT. rst mid-fetch
//   abandons the request; imem shares rst, so no stale imem_ready follows.
//  States: BOOT -> FETCH (one cycle). FETCH: imem_req=1, imem_addr=pc; req and addr
//   held stable until imem_ready. ready & !squash & !stall: if_*<=response, pc<=next.
//   ready & !squash & stall: response->skid, pc<=next, go HOLD. ready & squash:
//   discard, clear squash, stay FETCH. HOLD: imem_req=0, if_* held; when stall=0,
//   skid->if_*, skid empty, go FETCH.
//  Any cycle with stall=0 and no write into if_*: if_valid<=0 (bubble). stall=1:
//   if_* hold. Fetch latency: ready cycle -> if_valid next edge. Zero-wait imem gives
//   one instruction per cycle (req stays high back-to-back).
//  next = pending redirect applied ? br target : pc+4 (32-bit wrap, no trap).
//  Redirect accepted only when br_flag & id_valid & !stall (single cycle). Let
//   K = DELAY_SLOT ? br_pc+4 : br_pc (last address to keep).
//   - Fetch in flight at K: mark pending; at its completion pc<=br_addr.
//   - Fetch in flight above K: set squash, pc<=br_addr (fetched after discard).
//   - No fetch in flight: pc<=br_addr immediately.
//   - DELAY_SLOT=0: if_valid<=0 and flush_ifid=1 in the accept cycle; skid cleared.
//  A redirect arriving in the same cycle as imem_ready: squash/pending rules use the
//   in-flight address; the discarded response never reaches if_*.
//  If imem_addr[1:0]!=0 after redirect: fetch it anyway; exceptions are handled elsewhere.
// TESTING
//  1 RESET_PC=0x3000, imem_ready=1 always -> imem_addr 0x3000,0x3004,0x3008 on
//    consecutive cycles; first if_valid=1 (if_pc=0x3000) 2 cycles after rst falls.
//  2 Two wait states per fetch -> imem_addr/req stable 3 cycles each; if_valid pulses
//    once per 3 cycles; PCs 0x3000,0x3004 in order.
//  3 stall=1 in the cycle imem_ready returns 0x3008 -> if_* keep 0x3004 during stall;
//    one cycle after stall=0, if_pc=0x3008; no loss, no duplicate.
//  4 DELAY_SLOT=1, taken branch br_pc=0x3008, br_addr=0x3100 -> ID sees
//    0x3008,0x300C,0x3100; flush_ifid stays 0.
//  5 DELAY_SLOT=0, same branch, 0x300C in flight -> flush_ifid=1 one cycle, 0x300C
//    response discarded, ID sees 0x3008 then 0x3100.
//  6 rst=1 while fetch of 0x3010 waits -> next cycle all outputs at reset values;
//    after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch port.
//   imem_req    fetch request, held with imem_addr until imem_ready
//   imem_addr   word-aligned fetch address
//   imem_ready  response valid; completes the outstanding request
//   imem_rdata  fetched instruction word
// master: the fetch unit; slave: the instruction memory.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage PC owner. Fetches one instruction at a time over the imem port,
// loads the IF/ID register, and applies ID-stage redirects with an optional
// delay slot, squashing wrong-path fetches.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               ID does not consume IF/ID this cycle
//   id_valid            ID holds a real instruction (qualifies br_flag)
//   br_flag/br_addr     taken redirect and its target
//   br_pc               PC of the branch/jump in ID
//   imem                fetch port (master side)
//   if_pc/if_instr      IF/ID register contents
//   if_valid            IF/ID holds a valid instruction
//   flush_ifid          one-cycle pulse when a redirect squashes IF/ID
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request outstanding at pc, waiting for imem_ready
// HOLD  | response parked in skid while ID stalls, no request
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   id_valid,
  input  logic                   br_flag,
  input  logic [31:0]            br_addr,
  input  logic [31:0]            br_pc,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr,
  output logic                   if_valid,
  output logic                   flush_ifid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        pend_q, pend_d;
  logic        squash_q, squash_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] if_pc_d, if_instr_d;
  logic        if_valid_d, flush_d;

  logic        accept;
  logic        at_k;
  logic        discard;
  logic [31:0] k_addr;
  logic [31:0] seq_pc;

  assign accept = br_flag & id_valid & ~stall;
  // K is the last sequential address that stays on the executed path.
  assign k_addr = DELAY_SLOT ? (br_pc + 32'd4) : br_pc;
  assign at_k   = (pc_q == k_addr);
  assign seq_pc = pc_q + 32'd4;

  // pc_q doubles as the in-flight address; redirects are parked in redir_q
  // so the request stays stable until imem_ready.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    pend_d       = pend_q;
    squash_d     = squash_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_pc_d      = if_pc;
    if_instr_d   = if_instr;
    if_valid_d   = stall ? if_valid : 1'b0;
    flush_d      = 1'b0;
    discard      = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (accept) pc_d = br_addr;
      end

      FETCH: begin
        if (imem.imem_ready) begin
          // A redirect in the completion cycle judges the address now returning.
          discard  = squash_q | (accept & ~at_k);
          pend_d   = 1'b0;
          squash_d = 1'b0;
          if (discard) begin
            pc_d = accept ? br_addr : redir_q;
          end else begin
            pc_d = accept ? br_addr : (pend_q ? redir_q : seq_pc);
            if (stall) begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem.imem_rdata;
              state_d      = HOLD;
            end else begin
              if_pc_d    = pc_q;
              if_instr_d = imem.imem_rdata;
              if_valid_d = 1'b1;
            end
          end
        end else if (accept) begin
          redir_d = br_addr;
          if (squash_q | ~at_k) squash_d = 1'b1;
          else                  pend_d   = 1'b1;
        end
      end

      HOLD: begin
        if (accept) pc_d = br_addr;
        if (!stall) begin
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          if_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase

    // Without a delay slot whatever sits behind the branch is wrong-path,
    // including a response just moved out of the skid.
    if (!DELAY_SLOT && accept) begin
      if_valid_d = 1'b0;
      flush_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      redir_q      <= 32'd0;
      pend_q       <= 1'b0;
      squash_q     <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      if_pc        <= 32'd0;
      if_instr     <= 32'd0;
      if_valid     <= 1'b0;
      flush_ifid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      pend_q       <= pend_d;
      squash_q     <= squash_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_pc        <= if_pc_d;
      if_instr     <= if_instr_d;
      if_valid     <= if_valid_d;
      flush_ifid   <= flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a delay-slot instance and a no-delay-slot
// instance share stimulus; sel picks which one is observed and which one
// receives br_flag. Instruction memory returns addr ^ MEM_KEY.
module tb_fetch_pc_unit;

  localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, stall, id_valid, br_flag, sel, imem_ready;
  logic [31:0] br_addr, br_pc;

  logic [31:0] pc1, instr1, pc0, instr0;
  logic        valid1, flush1, valid0, flush0;

  fetch_pc_unit_if bus1 ();
  fetch_pc_unit_if bus0 ();

  assign bus1.imem_ready = imem_ready;
  assign bus1.imem_rdata = bus1.imem_addr ^ MEM_KEY;
  assign bus0.imem_ready = imem_ready;
  assign bus0.imem_rdata = bus0.imem_addr ^ MEM_KEY;

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid),
    .br_flag(br_flag & ~sel), .br_addr(br_addr), .br_pc(br_pc),
    .imem(bus1), .if_pc(pc1), .if_instr(instr1), .if_valid(valid1),
    .flush_ifid(flush1)
  );

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid),
    .br_flag(br_flag & sel), .br_addr(br_addr), .br_pc(br_pc),
    .imem(bus0), .if_pc(pc0), .if_instr(instr0), .if_valid(valid0),
    .flush_ifid(flush0)
  );

  logic        o_req, o_valid, o_flush;
  logic [31:0] o_addr, o_pc, o_instr;
  assign o_req   = sel ? bus0.imem_req  : bus1.imem_req;
  assign o_addr  = sel ? bus0.imem_addr : bus1.imem_addr;
  assign o_valid = sel ? valid0 : valid1;
  assign o_flush = sel ? flush0 : flush1;
  assign o_pc    = sel ? pc0    : pc1;
  assign o_instr = sel ? instr0 : instr1;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One record per clock: inputs, bus expected before the edge,
  // IF/ID expected after it.
  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic s, input logic y, input logic q,
                              input logic [31:0] a, input logic v, input logic [31:0] p);
    mk = '{r, s, y, q, a, v, p};
  endfunction

  logic [31:0] seen [$];
  int          flushes;
  logic [31:0] exp_seq [7];

  // Reset, then run ncyc cycles with the ID model branching once when
  // it holds 0x3008. Records every valid IF/ID PC and every flush pulse.
  task automatic run_branch(input logic use_ds0, input logic [31:0] tgt,
                            input logic [15:0] rdy_pat, input int ncyc);
    logic fired;
    fired      = 1'b0;
    sel        = use_ds0;
    seen.delete();
    flushes    = 0;
    br_flag    = 1'b0;
    id_valid   = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    br_pc      = 32'h0000_3008;
    br_addr    = tgt;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      imem_ready = rdy_pat[c];
      id_valid   = o_valid;
      br_flag    = !fired && o_valid && (o_pc == 32'h0000_3008);
      if (br_flag) fired = 1'b1;
      @(posedge clk);
      #1;
      br_flag = 1'b0;
      if (o_valid) seen.push_back(o_pc);
      if (o_flush) flushes++;
    end
  endtask

  task automatic check_seq(input string name, input int n, input int exp_flush);
    chk($sformatf("%s.count", name), seen.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.pc%0d", name, i), (i < seen.size()) ? seen[i] : 32'hDEAD_DEAD, exp_seq[i]);
    chk($sformatf("%s.flushes", name), flushes, exp_flush);
  endtask

  initial begin
    //              rst  stl  rdy  req  addr           vld  if_pc
    vecs[0]  = mk(1'b0,1'b0,1'b1,1'b0,32'h0000_3000,1'b0,32'h0000_0000);
    vecs[1]  = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3000,1'b1,32'h0000_3000);
    vecs[2]  = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3004,1'b1,32'h0000_3004);
    vecs[3]  = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3008,1'b1,32'h0000_3008);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b1,32'h0000_300C,1'b0,32'h0000_0000);
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0000_3000,1'b0,32'h0000_0000);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3000,1'b0,32'h0000_0000);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3000,1'b0,32'h0000_0000);
    vecs[8]  = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3000,1'b1,32'h0000_3000);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3004,1'b0,32'h0000_3000);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3004,1'b0,32'h0000_3000);
    vecs[11] = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3004,1'b1,32'h0000_3004);
    vecs[12] = mk(1'b0,1'b1,1'b1,1'b1,32'h0000_3008,1'b1,32'h0000_3004);
    vecs[13] = mk(1'b0,1'b1,1'b0,1'b0,32'h0000_300C,1'b1,32'h0000_3004);
    vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h0000_300C,1'b1,32'h0000_3008);
    vecs[15] = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_300C,1'b1,32'h0000_300C);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3010,1'b0,32'h0000_300C);
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_3010,1'b0,32'h0000_300C);
    vecs[18] = mk(1'b1,1'b0,1'b0,1'b1,32'h0000_3010,1'b0,32'h0000_0000);
    vecs[19] = mk(1'b0,1'b0,1'b1,1'b0,32'h0000_3000,1'b0,32'h0000_0000);
    vecs[20] = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3000,1'b1,32'h0000_3000);
    vecs[21] = mk(1'b0,1'b1,1'b0,1'b1,32'h0000_3004,1'b1,32'h0000_3000);
    vecs[22] = mk(1'b0,1'b0,1'b1,1'b1,32'h0000_3004,1'b1,32'h0000_3004);

    sel        = 1'b0;
    rst        = 1'b1;
    stall      = 1'b0;
    id_valid   = 1'b0;
    br_flag    = 1'b0;
    br_addr    = 32'd0;
    br_pc      = 32'd0;
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req",   o_req,   32'd0);
    chk("reset.addr",  o_addr,  32'h0000_3000);
    chk("reset.pc",    o_pc,    32'd0);
    chk("reset.instr", o_instr, 32'd0);
    chk("reset.valid", o_valid, 32'd0);
    chk("reset.flush", o_flush, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      rst        = vecs[i].rst;
      stall      = vecs[i].stall;
      imem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d.req", i),  o_req,  vecs[i].exp_req);
      chk($sformatf("v%0d.addr", i), o_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), o_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d.pc", i),    o_pc,    vecs[i].exp_pc);
      chk($sformatf("v%0d.flush", i), o_flush, 32'd0);
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d.instr", i), o_instr, vecs[i].exp_pc ^ MEM_KEY);
    end

    // Delay slot, zero-wait: slot 0x300C executes, then target.
    run_branch(1'b0, 32'h0000_3100, 16'hFFFF, 8);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104, 32'h3108};
    check_seq("ds1_zw", 7, 0);

    // No delay slot, zero-wait: 0x300C response discarded, one flush.
    run_branch(1'b1, 32'h0000_3100, 16'hFFFF, 8);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h3104, 32'h3108, 32'h0};
    check_seq("ds0_zw", 6, 1);

    // Delay slot with a wait state: redirect lands while 0x300C is pending.
    run_branch(1'b0, 32'h0000_3100, 16'h5554, 14);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104, 32'h0};
    check_seq("ds1_ws", 6, 0);

    // No delay slot with a wait state: in-flight 0x300C squashed on return.
    run_branch(1'b1, 32'h0000_3100, 16'h5554, 14);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h3104, 32'h0, 32'h0};
    check_seq("ds0_ws", 5, 1);

    // Sequential PC wraps past the top of the address space.
    run_branch(1'b0, 32'hFFFF_FFF8, 16'hFFFF, 8);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    check_seq("ds1_wrap", 7, 0);

    // Misaligned target is fetched as-is.
    run_branch(1'b1, 32'h0000_3102, 16'hFFFF, 8);
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3102, 32'h3106, 32'h310A, 32'h0};
    check_seq("ds0_misal", 6, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
